prog_seq: RTL and testbench

Program sequencer that drives the 18-bit instruction word into the three-register CPU core. It stores a short program loaded over a valid/ready port and, on command, issues it one instruction at a time. Each word is held stable for a fixed number of clock cycles. The sequencer sits in front of the core's `ins` input and stands in for the testbench `proc` task in integrated runs.

---
 rtl/prog_seq.sv | 141 ++++++++++++++
 tb/tb_prog_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_seq.sv
// Program sequencer: it loads a short instruction program over a valid/ready port, then issues
// the words one after another, holding each for `hold` cycles. Define PROG_SEQ_LOOP_EN to enable looping.
module prog_seq #(
   parameter int op_width   = 3,
   parameter int ra_width   = 5,
   parameter int ins_width  = op_width + 3*ra_width,
   parameter int depth      = 16,
   parameter int addr_width = $clog2(depth),
   parameter int hold       = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld_valid,
   input  logic [ins_width-1:0]  ld_data,
   output logic                  ld_ready,
   input  logic                  ld_clr,
   input  logic                  start,
   input  logic                  halt,
   input  logic                  loop,
   output logic [ins_width-1:0]  ins,
   output logic                  ins_valid,
   output logic [addr_width-1:0] pc,
   output logic                  busy,
   output logic                  done
);

   localparam int cnt_width = (hold > 1) ? $clog2(hold) : 1;
   localparam logic [cnt_width-1:0]  cnt_last = cnt_width'(hold - 1);
   localparam logic [addr_width:0]   wp_full  = (addr_width + 1)'(depth);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                state_q, state_d;
   logic [addr_width:0]   wp_q, wp_d;
   logic [addr_width-1:0] pc_q, pc_d;
   logic [ins_width-1:0]  ins_q, ins_d;
   logic [cnt_width-1:0]  cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  halt_q, halt_d;

   logic [ins_width-1:0]  mem [depth];
   logic                  ld_fire;
   logic                  halt_any;
   logic [addr_width-1:0] pc_next;

   assign ld_ready  = (state_q == IDLE) && (wp_q != wp_full) && !start && !ld_clr;
   assign ld_fire   = ld_valid && ld_ready;
   assign halt_any  = halt_q || halt;
   assign pc_next   = pc_q + addr_width'(1);

   assign ins       = ins_q;
   assign ins_valid = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign pc        = pc_q;
   assign done      = done_q;

`ifndef PROG_SEQ_LOOP_EN
   logic unused_loop;
   assign unused_loop = loop;
`endif

   // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      pc_d    = pc_q;
      ins_d   = ins_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      halt_d  = halt_q;
      case (state_q)
         IDLE: begin
            halt_d = 1'b0;
            if (ld_clr)       wp_d = '0;
            else if (ld_fire) wp_d = wp_q + (addr_width + 1)'(1);
            // A clear in the same cycle as start wins, so the run never begins with an empty program.
            if (start && !ld_clr && (wp_q != '0)) begin
               state_d = RUN;
               pc_d    = '0;
               ins_d   = mem[0];
               cnt_d   = '0;
            end
         end
         RUN: begin
            halt_d = halt_any;
            if (cnt_q == cnt_last) begin
               if (!halt_any && (({1'b0, pc_q} + (addr_width + 1)'(1)) < wp_q)) begin
                  pc_d  = pc_next;
                  ins_d = mem[pc_next];
                  cnt_d = '0;
               end
`ifdef PROG_SEQ_LOOP_EN
               else if (!halt_any && loop) begin
                  pc_d  = '0;
                  ins_d = mem[0];
                  cnt_d = '0;
               end
`endif
               else begin
                  state_d = IDLE;
                  pc_d    = '0;
                  ins_d   = '0;
                  cnt_d   = '0;
                  done_d  = 1'b1;
                  halt_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + cnt_width'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples its pre-edge inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wp_q    <= '0;
         pc_q    <= '0;
         ins_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         pc_q    <= pc_d;
         ins_q   <= ins_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         halt_q  <= halt_d;
      end
   end

   // NOTE: the program memory has no reset; only locations below wp are ever read.
   always_ff @(posedge clk) begin
      if (ld_fire) mem[wp_q[addr_width-1:0]] <= ld_data;
   end

endmodule

// File: tb/tb_prog_seq.sv
// Directed testbench for prog_seq with hand-computed expected values (hold=2, depth=16).
module tb_prog_seq;

   localparam int iw = 18;
   localparam int aw = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ld_valid, ld_clr, start, halt, loop;
   logic [iw-1:0] ld_data;
   logic          ld_ready;
   logic [iw-1:0] ins;
   logic          ins_valid, busy, done;
   logic [aw-1:0] pc;

   int n_checks = 0;
   int n_errors = 0;

   logic [iw-1:0] prog [4];

   prog_seq dut (
      .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .ld_clr(ld_clr), .start(start), .halt(halt), .loop(loop), .ins(ins), .ins_valid(ins_valid),
      .pc(pc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ld_valid = 0; ld_clr = 0; start = 0; halt = 0; loop = 0; ld_data = '0;
      #12;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic clear_prog();
      ld_clr = 1'b1;
      tick();
      ld_clr = 1'b0;
   endtask

   task automatic load_words(input int n);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = prog[i];
         tick();
      end
      ld_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      #1;
      check("ld_ready_low_on_start", ld_ready, 0);
      tick();
      start = 1'b0;
   endtask

   initial begin
      prog[0] = 18'h00041; prog[1] = 18'h20C41; prog[2] = 18'h31065; prog[3] = 18'h39484;

      // Reset state
      do_reset();
      check("rst_ins", ins, 0);
      check("rst_ins_valid", ins_valid, 0);
      check("rst_pc", pc, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ld_ready", ld_ready, 1);

      // Basic 4-word run: word k for two cycles each, done after 8 cycles
      load_words(4);
      do_start();
      for (int c = 0; c < 8; c++) begin
         check("run_ins", ins, prog[c/2]);
         check("run_pc", pc, c/2);
         check("run_valid", ins_valid, 1);
         check("run_busy", busy, 1);
         check("run_ld_ready", ld_ready, 0);
         check("run_no_done", done, 0);
         tick();
      end
      check("end_done", done, 1);
      check("end_ins", ins, 0);
      check("end_valid", ins_valid, 0);
      check("end_pc", pc, 0);
      check("end_busy", busy, 0);
      tick();
      check("end_done_pulse", done, 0);
      check("end_ld_ready", ld_ready, 1);

      // Start during RUN is ignored: restart and assert start again mid-run
      do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_ignored_pc", pc, 0);
      check("restart_ignored_cnt", ins, prog[0]);
      tick();
      check("restart_ignored_adv", ins, prog[1]);
      for (int c = 0; c < 6; c++) tick();
      check("restart_done", done, 1);
      tick();

      // Overflow: 17 offers, 16 accepted
      clear_prog();
      for (int i = 0; i < 17; i++) begin
         ld_valid = 1'b1;
         ld_data  = 18'h100 + 18'(i);
         #1;
         check("ovf_ld_ready", ld_ready, (i < 16) ? 1 : 0);
         tick();
      end
      ld_valid = 1'b0;
      check("ovf_full", ld_ready, 0);
      do_start();
      for (int c = 0; c < 32; c++) begin
         check("ovf_ins", ins, 18'h100 + 18'(c/2));
         tick();
      end
      check("ovf_done", done, 1);
      check("ovf_ins_after", ins, 0);
      tick();

      // Halt during word 1: word 1 finishes its hold, run ends
      clear_prog();
      load_words(4);
      do_start();
      tick(); tick();
      check("halt_w1_first", ins, prog[1]);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("halt_w1_held", ins, prog[1]);
      check("halt_no_done_yet", done, 0);
      tick();
      check("halt_done", done, 1);
      check("halt_ins", ins, 0);
      check("halt_busy", busy, 0);
      tick();
      check("halt_done_once", done, 0);
      check("halt_stays_idle", busy, 0);

      // Halt in the last hold cycle of a word also ends the run after it
      do_start();
      tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("halt_late_done", done, 1);
      check("halt_late_ins", ins, 0);
      tick();

      // Halt in IDLE has no effect on the next run
      halt = 1'b1;
      tick();
      halt = 1'b0;
      do_start();
      tick(); tick();
      check("idle_halt_ignored", ins, prog[1]);
      for (int c = 0; c < 6; c++) tick();
      check("idle_halt_done", done, 1);
      tick();

      // Start with an empty program
      clear_prog();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("empty_busy", busy, 0);
      check("empty_done", done, 0);
      tick();
      check("empty_done2", done, 0);
      check("empty_valid", ins_valid, 0);

      // Loop behaviour on a 2-word program
      load_words(2);
      loop = 1'b1;
      do_start();
`ifdef PROG_SEQ_LOOP_EN
      for (int c = 0; c < 8; c++) begin
         check("loop_ins", ins, prog[(c/2)%2]);
         check("loop_no_done", done, 0);
         tick();
      end
      halt = 1'b1;
      check("loop_halt_w0", ins, prog[0]);
      tick();
      halt = 1'b0;
      check("loop_halt_hold", ins, prog[0]);
      tick();
      check("loop_done", done, 1);
      check("loop_ins_end", ins, 0);
      tick();
      check("loop_done_once", done, 0);
`else
      for (int c = 0; c < 4; c++) begin
         check("noloop_ins", ins, prog[c/2]);
         tick();
      end
      check("noloop_done", done, 1);
      check("noloop_ins_end", ins, 0);
      tick();
      check("noloop_idle", busy, 0);
`endif
      loop = 1'b0;

      // Async reset mid-run
      clear_prog();
      load_words(4);
      do_start();
      tick(); tick(); tick();
      check("prerst_ins", ins, prog[1]);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ins", ins, 0);
      check("arst_valid", ins_valid, 0);
      check("arst_pc", pc, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("arst_ld_ready", ld_ready, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("arst_wp_zero", busy, 0);
      tick();
      check("arst_no_done", done, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
